fismos_axil_master: RTL



---
 rtl/fismos_axil_pkg.sv | 44 ++++
 rtl/fismos_axil_wr_chan.sv | 60 ++++++
 rtl/fismos_axil_master.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fismos_axil_pkg.sv
// ============================================================================
// Module      : fismos_axil_pkg
// Description : Shared types and constants for the FISMOS AXI4-Lite master
//               bridge (state encoding, AXI response/protection codes and
//               default address window).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fismos_axil_pkg;

    // Bridge state encoding, explicit 3-bit width
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_WAIT_B = 3'd2,
        ST_RD     = 3'd3,
        ST_WAIT_R = 3'd4,
        ST_RESP   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Unprivileged, secure; bit 2 marks an instruction access
    localparam logic [2:0] AXI_PROT_DATA  = 3'b000;
    localparam logic [2:0] AXI_PROT_INSTR = 3'b100;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;
    localparam logic [31:0] DEFAULT_ADDR_MASK = 32'hF000_0000;

    // Any non-OKAY response (EXOKAY included) is flagged, since the bridge
    // never issues exclusive accesses.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fismos_axil_wr_chan.sv
// ============================================================================
// Module      : fismos_axil_wr_chan
// Description : Tracks the independent AW and W handshakes of one write.
//               Each VALID drops the cycle after its own handshake; done_o
//               is raised in the cycle the second handshake completes.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fismos_axil_wr_chan (
    input  logic clk,
    input  logic resetn,
    input  logic start_i,
    input  logic active_i,
    input  logic awready_i,
    input  logic wready_i,
    output logic awvalid_o,
    output logic wvalid_o,
    output logic done_o
);

    logic aw_done_q, aw_done_d;
    logic w_done_q,  w_done_d;
    logic aw_hs, w_hs;

    assign aw_hs = awvalid_o & awready_i;
    assign w_hs  = wvalid_o & wready_i;

    // Completion flags: cleared when a new write is accepted, set on handshake
    always_comb begin
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        if (start_i) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else begin
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
        end
    end

    // Flag registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign awvalid_o = active_i & ~aw_done_q;
    assign wvalid_o  = active_i & ~w_done_q;
    assign done_o    = active_i & (aw_done_q | aw_hs) & (w_done_q | w_hs);

endmodule

`default_nettype wire

// File: rtl/fismos_axil_master.sv
// ============================================================================
// Module      : fismos_axil_master
// Description : PicoRV32 native memory interface to AXI4-Lite master bridge.
//               Requests inside the address window become single AXI-Lite
//               transactions; mem_ready pulses once per completed access.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fismos_axil_master
    import fismos_axil_pkg::*;
#(
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter int          AXI_DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter logic [31:0] ADDR_MASK      = DEFAULT_ADDR_MASK
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        mem_valid,
    input  logic                        mem_instr,
    input  logic [31:0]                 mem_addr,
    input  logic [31:0]                 mem_wdata,
    input  logic [3:0]                  mem_wstrb,
    output logic                        mem_ready,
    output logic [31:0]                 mem_rdata,
    output logic                        M_AXI_AWVALID,
    input  logic                        M_AXI_AWREADY,
    output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                  M_AXI_AWPROT,
    output logic                        M_AXI_WVALID,
    input  logic                        M_AXI_WREADY,
    output logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [3:0]                  M_AXI_WSTRB,
    input  logic                        M_AXI_BVALID,
    output logic                        M_AXI_BREADY,
    input  logic [1:0]                  M_AXI_BRESP,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                  M_AXI_ARPROT,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    output logic                        bus_err,
    input  logic                        err_clr
);

    state_t                       state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [3:0]                   wstrb_q, wstrb_d;
    logic                         instr_q, instr_d;
    logic [31:0]                  rdata_q, rdata_d;
    logic                         bus_err_q, bus_err_d;

    logic                         hit;
    logic                         accept;
    logic                         wr_done;
    logic                         err_set;
    logic [31:0]                  addr_local;

    // Window decode only matters in IDLE; outside it the bridge stays silent
    assign hit        = mem_valid & ((mem_addr & ADDR_MASK) == BASE_ADDR);
    assign accept     = (state_q == ST_IDLE) & hit;
    assign addr_local = mem_addr & ~ADDR_MASK;

    assign err_set = ((state_q == ST_WAIT_B) & M_AXI_BVALID & resp_is_err(M_AXI_BRESP)) |
                     ((state_q == ST_WAIT_R) & M_AXI_RVALID & resp_is_err(M_AXI_RRESP));

    fismos_axil_wr_chan u_wr_chan (
        .clk       (clk),
        .resetn    (resetn),
        .start_i   (accept),
        .active_i  (state_q == ST_WR),
        .awready_i (M_AXI_AWREADY),
        .wready_i  (M_AXI_WREADY),
        .awvalid_o (M_AXI_AWVALID),
        .wvalid_o  (M_AXI_WVALID),
        .done_o    (wr_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; DONE is a guard cycle so a retiring request cannot retrigger
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (hit) state_d = (mem_wstrb != 4'b0000) ? ST_WR : ST_RD;
            ST_WR:     if (wr_done) state_d = ST_WAIT_B;
            ST_WAIT_B: if (M_AXI_BVALID) state_d = ST_RESP;
            ST_RD:     if (M_AXI_ARREADY) state_d = ST_WAIT_R;
            ST_WAIT_R: if (M_AXI_RVALID) state_d = ST_RESP;
            ST_RESP:   state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        M_AXI_ARVALID = (state_q == ST_RD);
        M_AXI_BREADY  = (state_q == ST_WAIT_B);
        M_AXI_RREADY  = (state_q == ST_WAIT_R);
        mem_ready     = (state_q == ST_RESP);
    end

    // Datapath next values: capture request at accept, read data on R, clear after RESP
    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        instr_d   = instr_q;
        rdata_d   = rdata_q;
        bus_err_d = bus_err_q;
        if (accept) begin
            addr_d  = AXI_ADDR_WIDTH'(addr_local);
            wdata_d = AXI_DATA_WIDTH'(mem_wdata);
            wstrb_d = mem_wstrb;
            instr_d = mem_instr;
        end
        if ((state_q == ST_WAIT_R) && M_AXI_RVALID) begin
            rdata_d = 32'(M_AXI_RDATA);
        end else if (state_q == ST_RESP) begin
            rdata_d = 32'h0;
        end
        // A new error in the same cycle as err_clr keeps the flag set
        if (err_set)      bus_err_d = 1'b1;
        else if (err_clr) bus_err_d = 1'b0;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= 4'b0000;
            instr_q   <= 1'b0;
            rdata_q   <= 32'h0;
            bus_err_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            instr_q   <= instr_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_AWPROT = AXI_PROT_DATA;
    assign M_AXI_ARPROT = instr_q ? AXI_PROT_INSTR : AXI_PROT_DATA;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign mem_rdata    = rdata_q;
    assign bus_err      = bus_err_q;

endmodule

`default_nettype wire
